// File: rtl/data_mem_sized.sv
// Single-port byte-addressable data memory for the MIPS load/store path.
// Sized, aligned loads/stores with extension, a 1-cycle response and optional zero-fill after reset.
module data_mem_sized #(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 64,
    parameter int ADDR_W         = 32,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);

    localparam int NB     = DATA_W / 8;
    localparam int LANE_W = $clog2(NB);
    localparam int IDX_W  = $clog2(DEPTH);

    // A request transfers on the rising edge where req_valid && req_ready; req_ready never
    // depends on req_valid, and the response always appears exactly one cycle later.

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             clr_we;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clr_we    = 1'b0;
        req_ready = 1'b0;
        init_done = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (CLEAR_ON_RESET) begin
                    clr_we = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == IDX_W'(DEPTH - 1)) state_d = ST_RUN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                req_ready = 1'b1;
                init_done = 1'b1;
            end
            default: state_d = ST_INIT;
        endcase
    end

    logic [LANE_W-1:0] lane;
    logic [IDX_W-1:0]  idx;
    logic [LANE_W+2:0] sh;
    logic              accept;
    logic              misalign, oor, unsup, err;

    assign lane   = req_addr[LANE_W-1:0];
    assign idx    = req_addr[LANE_W +: IDX_W];
    assign sh     = {lane, 3'b000};
    assign accept = req_valid & req_ready;

    always_comb begin
        case (req_size)
            2'd0:    misalign = 1'b0;
            2'd1:    misalign = req_addr[0];
            2'd2:    misalign = |req_addr[1:0];
            default: misalign = |req_addr[2:0];
        endcase
    end

    assign oor   = |(req_addr >> (LANE_W + IDX_W));
    assign unsup = (req_size == 2'd3) && (DATA_W == 32);
    assign err   = misalign | oor | unsup;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] wshift, rword, rshift, smask, load_val;
    logic [NB-1:0]     bsz, be;
    logic              sbit;

    assign rword  = mem[idx];
    assign rshift = rword >> sh;
    assign wshift = req_wdata << sh;
    assign be     = bsz << lane;

    always_comb begin
        case (req_size)
            2'd0: begin
                smask = DATA_W'(8'hFF);
                bsz   = NB'(1);
                sbit  = rshift[7];
            end
            2'd1: begin
                smask = DATA_W'(16'hFFFF);
                bsz   = NB'(3);
                sbit  = rshift[15];
            end
            2'd2: begin
                smask = DATA_W'(32'hFFFF_FFFF);
                bsz   = NB'(15);
                sbit  = rshift[31];
            end
            default: begin
                smask = '1;
                bsz   = '1;
                sbit  = rshift[DATA_W-1];
            end
        endcase
        load_val = rshift & smask;
        if (req_signed && sbit) load_val = load_val | ~smask;
    end

    // RAM array is deliberately unreset; the INIT sweep is what zeroes it.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[cnt_q] <= '0;
        end else if (accept && req_we && !err) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wshift[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= accept;
            if (accept) begin
                rsp_err   <= err;
                rsp_rdata <= (req_we || err) ? '0 : load_val;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_sized.sv
// Bench for data_mem_sized: byte-array model checked every cycle plus directed literal vectors.
module tb_data_mem_sized;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 32;
    localparam int NB     = 4;

    logic              clk;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              init_done;

    data_mem_sized #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .init_done(init_done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Model: a flat byte array, an init cycle counter and the last response.
    logic [7:0]  mbytes [DEPTH*NB];
    int          init_cnt = 0;
    logic        pend_v   = 1'b0;
    logic [31:0] hold_d   = '0;
    logic        hold_e   = 1'b0;
    logic        exp_ready;

    assign exp_ready = (init_cnt == DEPTH);

    function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
        int nb;
        nb = 1 << sz;
        return (sz == 2'd3) || ((a % nb) != 0) || (a >= DEPTH * NB);
    endfunction

    function automatic logic [32:0] model_rsp(input logic we, input logic [1:0] sz,
                                              input logic sg, input logic [31:0] a);
        int nb;
        logic [31:0] v;
        nb = 1 << sz;
        if (model_err(sz, a) || we) return {model_err(sz, a), 32'h0};
        v = '0;
        for (int i = 0; i < nb; i++) v = v | (32'(mbytes[int'(a) + i]) << (8 * i));
        if (sg && nb < 4 && v[8*nb-1]) v = v | ~((32'h1 << (8 * nb)) - 32'h1);
        return {1'b0, v};
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            init_cnt <= 0;
            pend_v   <= 1'b0;
            hold_d   <= '0;
            hold_e   <= 1'b0;
            for (int i = 0; i < DEPTH * NB; i++) mbytes[i] <= 8'h00;
        end else begin
            pend_v <= 1'b0;
            if (init_cnt < DEPTH) init_cnt <= init_cnt + 1;
            if (req_valid && init_cnt == DEPTH) begin
                pend_v           <= 1'b1;
                {hold_e, hold_d} <= model_rsp(req_we, req_size, req_signed, req_addr);
                if (req_we && !model_err(req_size, req_addr)) begin
                    for (int i = 0; i < (1 << req_size); i++)
                        mbytes[int'(req_addr) + i] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    // scoreboard compare, every cycle on the falling edge
    always @(negedge clk) begin
        check("cyc_req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
        check("cyc_init_done", {31'b0, init_done}, {31'b0, exp_ready});
        check("cyc_rsp_valid", {31'b0, rsp_valid}, {31'b0, pend_v});
        check("cyc_rsp_rdata", rsp_rdata, hold_d);
        check("cyc_rsp_err",   {31'b0, rsp_err},   {31'b0, hold_e});
    end

    // driver tasks: called at posedge+1, return at the posedge+1 after the accept edge
    task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic load_chk(input string name, input logic [1:0] sz, input logic sg,
                            input logic [31:0] a, input logic [31:0] exp_d, input logic exp_e);
        issue(1'b0, sz, sg, a, 32'h0);
        check({name, "_valid"}, {31'b0, rsp_valid}, 32'h1);
        check({name, "_data"},  rsp_rdata, exp_d);
        check({name, "_err"},   {31'b0, rsp_err}, {31'b0, exp_e});
    endtask

    task automatic store_chk(input string name, input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] wd, input logic exp_e);
        issue(1'b1, sz, 1'b0, a, wd);
        check({name, "_valid"}, {31'b0, rsp_valid}, 32'h1);
        check({name, "_data"},  rsp_rdata, 32'h0);
        check({name, "_err"},   {31'b0, rsp_err}, {31'b0, exp_e});
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (req_ready !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int n;

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", {31'b0, req_ready}, 32'h0);
        check("rst_init_done", {31'b0, init_done}, 32'h0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        reset = 1'b1;

        wait_ready(n);
        check("init_cycles", n, 64);
        check("init_done_up", {31'b0, init_done}, 32'h1);

        load_chk("lw_cleared", 2'd2, 1'b0, 32'h24, 32'h0000_0000, 1'b0);

        store_chk("sw_10", 2'd2, 32'h10, 32'h8899_AABC, 1'b0);
        load_chk("lb_10",  2'd0, 1'b1, 32'h10, 32'hFFFF_FFBC, 1'b0);
        load_chk("lbu_13", 2'd0, 1'b0, 32'h13, 32'h0000_0088, 1'b0);
        load_chk("lh_12",  2'd1, 1'b1, 32'h12, 32'hFFFF_8899, 1'b0);
        load_chk("lhu_10", 2'd1, 1'b0, 32'h10, 32'h0000_AABC, 1'b0);
        load_chk("lb_11u", 2'd0, 1'b0, 32'h11, 32'h0000_00AA, 1'b0);

        store_chk("sb_11", 2'd0, 32'h11, 32'hFFFF_FF55, 1'b0);
        load_chk("lw_10",  2'd2, 1'b0, 32'h10, 32'h8899_55BC, 1'b0);

        store_chk("sh_16", 2'd1, 32'h16, 32'hABCD_7F01, 1'b0);
        load_chk("lw_14",  2'd2, 1'b0, 32'h14, 32'h7F01_0000, 1'b0);
        load_chk("lh_16",  2'd1, 1'b1, 32'h16, 32'h0000_7F01, 1'b0);

        load_chk("lh_01_mis",  2'd1, 1'b0, 32'h01, 32'h0, 1'b1);
        load_chk("lw_02_mis",  2'd2, 1'b0, 32'h02, 32'h0, 1'b1);
        load_chk("lw_100_oor", 2'd2, 1'b0, 32'h100, 32'h0, 1'b1);
        load_chk("lw_hi_oor",  2'd2, 1'b0, 32'h8000_0010, 32'h0, 1'b1);
        load_chk("ld_unsup",   2'd3, 1'b0, 32'h00, 32'h0, 1'b1);
        store_chk("sw_12_mis", 2'd2, 32'h12, 32'hDEAD_BEEF, 1'b1);
        store_chk("sw_oor",    2'd2, 32'h200, 32'hDEAD_BEEF, 1'b1);
        store_chk("sd_unsup",  2'd3, 32'h10, 32'hDEAD_BEEF, 1'b1);
        load_chk("lw_00_keep", 2'd2, 1'b0, 32'h00, 32'h0000_0000, 1'b0);
        load_chk("lw_10_keep", 2'd2, 1'b0, 32'h10, 32'h8899_55BC, 1'b0);

        store_chk("sw_00", 2'd2, 32'h00, 32'h1111_2222, 1'b0);
        store_chk("sw_04", 2'd2, 32'h04, 32'h3333_4444, 1'b0);
        store_chk("sw_08", 2'd2, 32'h08, 32'h5555_AAAA, 1'b0);
        load_chk("b2b_00", 2'd2, 1'b0, 32'h00, 32'h1111_2222, 1'b0);
        load_chk("b2b_04", 2'd2, 1'b0, 32'h04, 32'h3333_4444, 1'b0);
        load_chk("b2b_08", 2'd2, 1'b0, 32'h08, 32'h5555_AAAA, 1'b0);
        @(posedge clk);
        #1;
        check("idle_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("idle_rsp_hold",  rsp_rdata, 32'h5555_AAAA);

        // reset right after an accept drops the pending response
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'd2;
        req_addr  = 32'h10;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset     = 1'b0;
        #1;
        check("run_rst_valid", {31'b0, rsp_valid}, 32'h0);
        check("run_rst_rdata", rsp_rdata, 32'h0);
        check("run_rst_ready", {31'b0, req_ready}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        wait_ready(n);
        check("init_cycles_2", n, 64);

        // reset pulse at sweep count 20
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        wait_ready(n);
        check("init_restart", n, 64);
        load_chk("lw_10_clr", 2'd2, 1'b0, 32'h10, 32'h0000_0000, 1'b0);
        load_chk("lw_08_clr", 2'd2, 1'b0, 32'h08, 32'h0000_0000, 1'b0);

        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
